// File: rtl/mips_pkg.sv
// Shared fetch-path definitions: instruction size, default reset PC, the queued
// {pc, instruction} entry and the fetch-legality check.
package mips_pkg;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // A fetch is illegal when misaligned or when its last byte falls past the memory.
    function automatic logic pc_bad(input logic [31:0] pc, input logic [31:0] last_pc);
        return (pc[1:0] != 2'b00) || (pc > last_pc);
    endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Small synchronous FIFO of fetched {pc, instruction} entries; flush empties it in one edge,
// and push/pop in the same cycle are both honoured.
module ifetch_queue
    import mips_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int CW     = $clog2(QDEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    fetch_entry_t  slots [QDEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(QDEPTH)) || do_pop);
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the consumer gates the head with a non-zero count.
    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush) slots[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/ifetch_sequencer.sv
// Program counter and fetch sequencing in front of a 1-cycle registered instruction memory,
// with a credit-limited output queue, redirect/flush and sticky fault reporting.
module ifetch_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          MEM_BYTES = 64,
    parameter int          QDEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    localparam int          CW      = $clog2(QDEPTH + 1);
    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - INSTR_BYTES);

    logic [31:0]   pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic          fault;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          pop;
    logic          issue;
    logic          pc_bad_now;
    logic [31:0]   credit;

    assign pop        = inst_valid & inst_ready;
    // Slots already owned (queued + in flight) after this cycle's pop; never underflows
    // because a pop implies a non-empty queue.
    assign credit     = 32'(count) + 32'(inflight) - 32'(pop);
    assign pc_bad_now = pc_bad(pc, LAST_PC);
    assign issue      = !fault && !redirect_valid && !pc_bad_now && (credit < 32'(QDEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            fault       <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
            fault    <= pc_bad(redirect_pc, LAST_PC);
        end else begin
            if (issue) begin
                inflight    <= 1'b1;
                inflight_pc <= pc;
                pc          <= pc + 32'(INSTR_BYTES);
            end else begin
                inflight <= 1'b0;
            end
            if (!fault && pc_bad_now) fault <= 1'b1;
        end
    end

    assign push_entry = '{pc: inflight_pc, inst: imem_rdata};

    ifetch_queue #(
        .QDEPTH (QDEPTH),
        .CW     (CW)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (inflight && !redirect_valid),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .count      (count)
    );

    assign imem_addr   = pc;
    assign inst_valid  = (count != '0);
    assign inst_data   = inst_valid ? head.inst : '0;
    assign inst_pc     = inst_valid ? head.pc : '0;
    assign fetch_fault = fault;

endmodule
